// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_EXEC  = 2'd2,
      S_ERROR = 2'd3
   } fetch_state_e;

   function automatic logic [ADDR_W-1:0] add32(
      input logic [ADDR_W-1:0] a,
      input logic [ADDR_W-1:0] b
   );
      return a + b;
   endfunction

   function automatic logic [ADDR_W-1:0] shl2(
      input logic [ADDR_W-1:0] a
   );
      return {a[ADDR_W-3:0], 2'b00};
   endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: sequential PC+4 or taken target PC+4+(offset<<2).
module pc_next_calc
   import fetch_pkg::*;
(
   input  logic [ADDR_W-1:0] i_pc,
   input  logic              i_b,
   input  logic              i_z,
   input  logic [ADDR_W-1:0] i_b_addr,
   output logic [ADDR_W-1:0] o_pc_next
);

   logic [ADDR_W-1:0] w_seq;
   logic [ADDR_W-1:0] w_off;
   logic [ADDR_W-1:0] w_tgt;

   assign w_seq     = add32(i_pc, PC_INC);
   assign w_off     = shl2(i_b_addr);
   assign w_tgt     = add32(w_seq, w_off);
   assign o_pc_next = (i_b & i_z) ? w_tgt : w_seq;

endmodule

// File: rtl/fetch_ctrl.sv
// Handshaked, stallable, timeout-checked PC sequencer for instruction fetch.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned       MAX_WAIT = 15
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Mem_Ack,
   input  logic [31:0]       Instr_In,
   input  logic              Resolve,
   input  logic              B,
   input  logic              Z,
   input  logic [ADDR_W-1:0] B_addr,
   input  logic              Stall,
   output logic              Mem_Req,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [31:0]       Instr_Out,
   output logic              Instr_Valid,
   output logic              Timeout_Err,
   output logic [ADDR_W-1:0] PC
);

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   fetch_state_e      r_state;
   fetch_state_e      w_state_nx;
   logic [7:0]        r_wait;
   logic [7:0]        w_wait_nx;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_next;
   logic [31:0]       r_instr;
   logic              r_valid;
   logic              w_capture;
   logic              w_advance;

   pc_next_calc u_pc_next (
      .i_pc      (r_pc),
      .i_b       (B),
      .i_z       (Z),
      .i_b_addr  (B_addr),
      .o_pc_next (w_pc_next)
   );

   always_comb begin
      w_state_nx = r_state;
      w_wait_nx  = r_wait;
      w_capture  = 1'b0;
      w_advance  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (Start) w_state_nx = S_REQ;
         end
         S_REQ: begin
            // an ack in the expiring cycle still wins
            if (Mem_Ack) begin
               w_capture  = 1'b1;
               w_wait_nx  = '0;
               w_state_nx = S_EXEC;
            end else if (r_wait == WAIT_LAST) begin
               w_state_nx = S_ERROR;
            end else begin
               w_wait_nx = r_wait + 8'd1;
            end
         end
         S_EXEC: begin
            if (Resolve && !Stall) begin
               w_advance  = 1'b1;
               w_state_nx = S_REQ;
            end
         end
         S_ERROR: begin
            w_state_nx = S_ERROR;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state <= S_IDLE;
         r_wait  <= '0;
         r_pc    <= RESET_PC;
         r_instr <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_wait  <= w_wait_nx;
         r_valid <= w_capture;
         if (w_capture) r_instr <= Instr_In;
         if (w_advance) r_pc <= w_pc_next;
      end
   end

   // Moore outputs: async reset of r_state drops Mem_Req at once
   assign Mem_Req     = (r_state == S_REQ);
   assign Timeout_Err = (r_state == S_ERROR);
   assign Mem_Addr    = r_pc;
   assign PC          = r_pc;
   assign Instr_Out   = r_instr;
   assign Instr_Valid = r_valid;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Multi-cycle sequencer for the instruction-fetch datapath. Owns the program counter and drives an instruction-memory request/acknowledge handshake. Holds each fetched instruction until the execute stage resolves the branch, then advances PC to PC+4 or to the branch target PC+4+(B_addr<<2). Sits between the instruction memory and the decode/ALU stage and replaces free-running PC update with a handshaked, stallable, timeout-checked one.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `MAX_WAIT`, default 15: number of REQ cycles without `Mem_Ack` before a timeout is declared (range 1..255).
- `Clock` in 1: single clock; all state changes on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `Start` in 1: leaves IDLE and begins fetching at the current PC.
- `Mem_Ack` in 1: instruction memory has valid data on `Instr_In` this cycle.
- `Instr_In` in 32: instruction word from memory.
- `Resolve` in 1: execute stage has a valid branch decision this cycle.
- `B` in 1: instruction is a branch.
- `Z` in 1: ALU zero flag.
- `B_addr` in 32: branch word offset, two's complement.
- `Stall` in 1: freezes the EXEC state.
- `Mem_Req` out 1: fetch request; high exactly while in REQ.
- `Mem_Addr` out 32: equals PC.
- `Instr_Out` out 32: last captured instruction.
- `Instr_Valid` out 1: one-cycle pulse after capture.
- `Timeout_Err` out 1: sticky error flag.
- `PC` out 32: current program counter.

## Operation
- States: IDLE, REQ, EXEC, ERROR.
- IDLE:
  - `Start`=1 → REQ.
  - `Start` is ignored in every other state.
- REQ:
  - `Mem_Req`=1 and `Mem_Addr`=PC.
  - A wait counter increments each REQ cycle without an ack.
  - `Mem_Ack`=1 → capture `Instr_In` into `Instr_Out`, clear the counter, go to EXEC.
  - Counter reaches MAX_WAIT with `Mem_Ack`=0 → ERROR.
  - If `Mem_Ack` arrives in the cycle the counter would expire, the ack wins.
- EXEC:
  - Advances only when `Resolve`=1 and `Stall`=0. Then PC ← (B&Z) ? PC+4+(B_addr<<2) : PC+4, and the state goes to REQ.
  - `Stall`=1 holds the state regardless of `Resolve`; a Resolve seen during a stall is not remembered.
  - `B`, `Z` and `B_addr` are sampled only on the advancing edge.
- ERROR:
  - `Timeout_Err`=1, `Mem_Req`=0, PC frozen.
  - Exit only by `Reset`.
- `Mem_Ack` outside REQ is ignored. `Instr_Out` keeps its value.
- Arithmetic:
  - All additions are 32-bit, modulo 2^32; the shift discards the top 2 bits of `B_addr`.
  - No carry or overflow indication.
  - Wrap-around is legal: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values: state IDLE, PC=`RESET_PC`, `Mem_Req`=0, `Mem_Addr`=`RESET_PC`, `Instr_Out`=0, `Instr_Valid`=0, `Timeout_Err`=0, wait counter 0.
- Reset mid-operation drops `Mem_Req` immediately (asynchronously) and abandons the outstanding request.
- `Mem_Req` is decoded from the registered state (Moore). It rises the cycle after the `Start` edge or the advancing EXEC edge.
- `Instr_Valid` is registered: high for exactly the one cycle following the capturing edge.
- `Instr_Out` updates on the capturing edge.
- Minimum instruction period is 2 cycles: ack in the first REQ cycle, then `Resolve` in the first EXEC cycle.
- PC and `Mem_Addr` change on the advancing edge and are stable throughout REQ.
- Timeout: with no ack, `Timeout_Err` rises MAX_WAIT cycles after entering REQ.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum (IDLE, REQ, EXEC, ERROR);
  - constant PC_INC=4;
  - the width constant ADDR_W=32.
- One sub-module, `pc_next_calc` (combinational): inputs PC, B, Z, B_addr; output next PC. It reuses the team's 32-bit adder and left-2 shifter.
- FSM, wait counter and output registers live in `fetch_ctrl`.

## Test plan
- Sequential fetch:
  - Stimulus: reset, `Start`; ack on the first REQ cycle; `Resolve`=1 with B=0.
  - Required: PC sequence 0, 4, 8; each `Instr_Valid` pulse one cycle wide; 2-cycle period.
- Taken branch:
  - Stimulus: at PC=8, B=1, Z=1, B_addr=3.
  - Required: next PC=24.
  - Variant B_addr=32'hFFFF_FFFE: next PC=4.
  - Variant B=1, Z=0: next PC=12.
- Stall:
  - Stimulus: in EXEC, `Stall`=1 for 3 cycles with `Resolve`=1.
  - Required: PC and state held.
  - Then `Stall`=0 with `Resolve`=1: advance on that edge.
- Timeout:
  - Stimulus: MAX_WAIT=4, never ack.
  - Required: `Timeout_Err`=1 after 4 REQ cycles; `Mem_Req`=0; stays set; cleared only by `Reset`.
- Ack/timeout race and stray ack:
  - Stimulus: ack in the expiring cycle.
  - Required: capture, EXEC entered, no error.
  - Stimulus: ack while in EXEC.
  - Required: `Instr_Out` unchanged.
- Reset mid-request:
  - Stimulus: assert `Reset` while in REQ at PC=16.
  - Required: `Mem_Req` falls without waiting for a clock edge; PC=`RESET_PC`; IDLE.
- PC wrap:
  - Stimulus: `RESET_PC`=32'hFFFF_FFFC, sequential advance.
  - Required: next PC=0.
